// File: rtl/grid_game_pkg.sv
// Shared types and board-coordinate helpers for the N x N K-in-a-row game engine.
package grid_game_pkg;

  typedef enum logic [1:0] {EMPTY = 2'b00, P0 = 2'b01, P1 = 2'b10} cell_t;
  typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, WIN = 2'd2, DRAW = 2'd3} state_t;
  typedef enum logic [1:0] {H = 2'd0, V = 2'd1, D = 2'd2, AD = 2'd3} dir_t;

  function automatic int idx_row(input int idx, input int n);
    return idx / n;
  endfunction

  function automatic int idx_col(input int idx, input int n);
    return idx % n;
  endfunction

  function automatic int rc_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  // Unit step of each scan direction; AD walks down-left so it covers the anti-diagonal.
  function automatic int dir_dr(input dir_t d);
    return (d == H) ? 0 : 1;
  endfunction

  function automatic int dir_dc(input dir_t d);
    case (d)
      H:       return 1;
      V:       return 0;
      D:       return 1;
      default: return -1;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// One raw active-low button: synchroniser chain, then a registered falling-edge press pulse.
module btn_edge_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_n,
  output logic press
);

  logic [SYNC_STG-1:0] sync_reg;
  logic                prev_reg;
  logic                press_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_reg  <= '0;
      prev_reg  <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STG-2:0], btn_n};
      prev_reg  <= sync_reg[SYNC_STG-1];
      press_reg <= prev_reg & ~sync_reg[SYNC_STG-1];
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/grid_game_ctrl.sv
// N x N K-in-a-row engine: button capture, vblank-gated commit, sequential line scan through the last move.
// Optional turn time limit is enabled by defining MOVE_TIMEOUT_EN.
module grid_game_ctrl
  import grid_game_pkg::*;
#(
  parameter int N           = 3,
  parameter int K           = 3,
  parameter int SYNC_STG    = 2,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N*N-1:0]             btn_n,
  input  logic                       restart,
  input  logic                       vnotactive,
  input  logic [$clog2(N*N)-1:0]     rd_idx,
  output logic [1:0]                 rd_cell,
  output logic                       player,
  output logic [1:0]                 state,
  output logic                       winner,
  output logic [$clog2(N*N+1)-1:0]   move_cnt
);

  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int MW    = $clog2(CELLS + 1);
  localparam int DW    = $clog2(K);
  localparam int RW    = $clog2(K + 1);

  logic [2*CELLS-1:0] board_reg, board_next;
  logic               player_reg, player_next;
  logic               winner_reg, winner_next;
  state_t             state_reg, state_next;
  logic [MW-1:0]      move_cnt_reg, move_cnt_next;
  logic               pend_valid_reg, pend_valid_next;
  logic [IW-1:0]      pend_idx_reg, pend_idx_next;
  logic [IW-1:0]      last_idx_reg, last_idx_next;
  dir_t               dir_reg, dir_next;
  logic               side_reg, side_next;
  logic [DW-1:0]      dist_reg, dist_next;
  logic [RW-1:0]      run_reg, run_next;

  logic [CELLS-1:0]   press;
  logic               press_found;
  logic [IW-1:0]      press_sel;
  logic               commit;
  logic [1:0]         own_code;
  logic [1:0]         rd_raw;
  int                 probe_r, probe_c, probe_idx;
  logic               probe_in, probe_match;

`ifdef MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] turn_reg, turn_next;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_btn
      btn_edge_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .CLK   (CLK),
        .RST   (RST),
        .btn_n (btn_n[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  assign own_code = player_reg ? P1 : P0;

  // Probe cell: dist steps from the last move along dir, side 0 forward, side 1 backward.
  always_comb begin
    int sgn;
    sgn         = side_reg ? -1 : 1;
    probe_r     = idx_row(int'(last_idx_reg), N) + sgn * dir_dr(dir_reg) * int'(dist_reg);
    probe_c     = idx_col(int'(last_idx_reg), N) + sgn * dir_dc(dir_reg) * int'(dist_reg);
    probe_in    = (probe_r >= 0) && (probe_r < N) && (probe_c >= 0) && (probe_c < N);
    probe_idx   = probe_in ? rc_idx(probe_r, probe_c, N) : 0;
    probe_match = probe_in && (board_reg[2*probe_idx +: 2] == own_code);
  end

  always_comb begin
    board_next      = board_reg;
    player_next     = player_reg;
    winner_next     = winner_reg;
    state_next      = state_reg;
    move_cnt_next   = move_cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_idx_next   = pend_idx_reg;
    last_idx_next   = last_idx_reg;
    dir_next        = dir_reg;
    side_next       = side_reg;
    dist_next       = dist_reg;
    run_next        = run_reg;
    commit          = 1'b0;
    press_found     = 1'b0;
    press_sel       = '0;

    for (int i = CELLS - 1; i >= 0; i--) begin
      if (press[i] && (board_reg[2*i +: 2] == EMPTY)) begin
        press_found = 1'b1;
        press_sel   = IW'(i);
      end
    end

    case (state_reg)
      PLAY: begin
        if (pend_valid_reg && vnotactive) begin
          commit                         = 1'b1;
          board_next[2*pend_idx_reg +: 2] = own_code;
          move_cnt_next                  = move_cnt_reg + MW'(1);
          pend_valid_next                = 1'b0;
          last_idx_next                  = pend_idx_reg;
          dir_next                       = H;
          side_next                      = 1'b0;
          dist_next                      = DW'(1);
          run_next                       = RW'(1);
          state_next                     = CHECK;
        end else if (!pend_valid_reg && press_found) begin
          pend_valid_next = 1'b1;
          pend_idx_next   = press_sel;
        end
      end
      CHECK: begin
        if (probe_match) begin
          if (int'(run_reg) + 1 >= K) begin
            winner_next = player_reg;
            state_next  = WIN;
          end else begin
            run_next  = run_reg + RW'(1);
            dist_next = dist_reg + DW'(1);
          end
        end else begin
          // A side ends at the board edge or the first mismatching cell.
          dist_next = DW'(1);
          if (!side_reg) begin
            side_next = 1'b1;
          end else begin
            side_next = 1'b0;
            run_next  = RW'(1);
            if (dir_reg == AD) begin
              if (move_cnt_reg == MW'(CELLS)) begin
                state_next = DRAW;
              end else begin
                player_next = ~player_reg;
                state_next  = PLAY;
              end
            end else begin
              dir_next = dir_t'(dir_reg + 2'd1);
            end
          end
        end
      end
      default: ;
    endcase

`ifdef MOVE_TIMEOUT_EN
    turn_next = '0;
    if ((state_reg == PLAY) && !commit) begin
      if (turn_reg == TW'(TIMEOUT_CYC - 1)) begin
        if (!pend_valid_reg) player_next = ~player_reg;
      end else begin
        turn_next = turn_reg + TW'(1);
      end
    end
`endif

    if (restart) begin
      board_next      = '0;
      player_next     = 1'b0;
      winner_next     = 1'b0;
      move_cnt_next   = '0;
      pend_valid_next = 1'b0;
      state_next      = PLAY;
`ifdef MOVE_TIMEOUT_EN
      turn_next       = '0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      board_reg      <= '0;
      player_reg     <= 1'b0;
      winner_reg     <= 1'b0;
      state_reg      <= PLAY;
      move_cnt_reg   <= '0;
      pend_valid_reg <= 1'b0;
      pend_idx_reg   <= '0;
      last_idx_reg   <= '0;
      dir_reg        <= H;
      side_reg       <= 1'b0;
      dist_reg       <= DW'(1);
      run_reg        <= RW'(1);
    end else begin
      board_reg      <= board_next;
      player_reg     <= player_next;
      winner_reg     <= winner_next;
      state_reg      <= state_next;
      move_cnt_reg   <= move_cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_idx_reg   <= pend_idx_next;
      last_idx_reg   <= last_idx_next;
      dir_reg        <= dir_next;
      side_reg       <= side_next;
      dist_reg       <= dist_next;
      run_reg        <= run_next;
    end
  end

`ifdef MOVE_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) turn_reg <= '0;
    else      turn_reg <= turn_next;
  end
`endif

  // Code 11 is never written, so treat it as corruption and show an empty cell.
  always_comb begin
    rd_raw = 2'b00;
    if (int'(rd_idx) < CELLS) rd_raw = board_reg[2*rd_idx +: 2];
    rd_cell = (rd_raw == 2'b11) ? 2'b00 : rd_raw;
  end

  assign player   = player_reg;
  assign state    = state_reg;
  assign winner   = winner_reg;
  assign move_cnt = move_cnt_reg;

endmodule

// File: tb/tb_grid_game_ctrl.sv
// Directed bench for grid_game_ctrl: a 3x3/K=3 and a 5x5/K=4 instance, checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_grid_game_ctrl;

  localparam int KIND_CELL = 0, KIND_PLAYER = 1, KIND_STATE = 2, KIND_WINNER = 3, KIND_CNT = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       restart, vnotactive;
  logic [8:0]  btn3;
  logic [24:0] btn5;
  logic [3:0]  rd_idx3;
  logic [4:0]  rd_idx5;
  logic [1:0]  rd_cell3, rd_cell5, state3, state5;
  logic        player3, player5, winner3, winner5;
  logic [3:0]  move_cnt3;
  logic [4:0]  move_cnt5;

  always #5 CLK = ~CLK;

  grid_game_ctrl #(.N(3), .K(3), .SYNC_STG(2), .TIMEOUT_CYC(16)) dut3 (
    .CLK(CLK), .RST(RST), .btn_n(btn3), .restart(restart), .vnotactive(vnotactive),
    .rd_idx(rd_idx3), .rd_cell(rd_cell3), .player(player3), .state(state3),
    .winner(winner3), .move_cnt(move_cnt3)
  );

  grid_game_ctrl #(.N(5), .K(4), .SYNC_STG(2), .TIMEOUT_CYC(16)) dut5 (
    .CLK(CLK), .RST(RST), .btn_n(btn5), .restart(restart), .vnotactive(vnotactive),
    .rd_idx(rd_idx5), .rd_cell(rd_cell5), .player(player5), .state(state5),
    .winner(winner5), .move_cnt(move_cnt5)
  );

  typedef struct { int which; int kind; int idx; int val; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int last_lat = -1;
  int mboard[2][25];
  int mplayer[2], mcnt[2], mstate[2], mwinner[2];
  int draw_ord[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  function automatic string kind_name(input int kind);
    case (kind)
      KIND_CELL:   return "cell";
      KIND_PLAYER: return "player";
      KIND_STATE:  return "state";
      KIND_WINNER: return "winner";
      default:     return "move_cnt";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int which, input int kind);
    case (kind)
      KIND_CELL:   return 32'(which ? rd_cell5 : rd_cell3);
      KIND_PLAYER: return 32'(which ? player5 : player3);
      KIND_STATE:  return 32'(which ? state5 : state3);
      KIND_WINNER: return 32'(which ? winner5 : winner3);
      default:     return which ? 32'(move_cnt5) : 32'(move_cnt3);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input int which, input int kind, input int idx, input int val);
    exp_t e;
    e.which = which; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge CLK);
      if (e.which == 0) rd_idx3 = 4'(e.idx);
      else              rd_idx5 = 5'(e.idx);
      #1;
      check($sformatf("n%0d_%s_%0d", e.which ? 5 : 3, kind_name(e.kind), e.idx),
            observe(e.which, e.kind), 32'(e.val));
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 25; i++) mboard[w][i] = 0;
      mplayer[w] = 0; mcnt[w] = 0; mstate[w] = 0; mwinner[w] = 0;
    end
  endtask

  task automatic set_btn(input int which, input int i, input logic v);
    if (which == 0) btn3[i] = v;
    else            btn5[i] = v;
  endtask

  // Hold the button(s) low for 3 cycles and watch 40 cycles; last_lat = CHECK cycles after commit.
  task automatic press(input int which, input int a, input int b);
    int c_commit, c_done;
    logic [31:0] cnt0;
    cnt0 = observe(which, KIND_CNT);
    c_commit = -1;
    c_done = -1;
    @(negedge CLK);
    set_btn(which, a, 1'b0);
    if (b >= 0) set_btn(which, b, 1'b0);
    for (int cy = 1; cy <= 40; cy++) begin
      @(negedge CLK);
      if (cy == 3) begin
        set_btn(which, a, 1'b1);
        if (b >= 0) set_btn(which, b, 1'b1);
      end
      if (c_commit < 0 && observe(which, KIND_CNT) != cnt0) c_commit = cy;
      if (c_commit >= 0 && c_done < 0 && observe(which, KIND_STATE) != 32'd1) c_done = cy;
    end
    last_lat = (c_done >= 0) ? c_done - c_commit : -1;
  endtask

  // outcome: 0 game continues, 2 this move wins, 3 this move draws.
  task automatic move(input int which, input int a, input int b, input int outcome);
    int pick;
    pick = -1;
    for (int i = 0; i < 25; i++)
      if (pick < 0 && (i == a || i == b) && mboard[which][i] == 0) pick = i;
    if (mstate[which] != 0) pick = -1;
    if (pick >= 0) begin
      mboard[which][pick] = mplayer[which] + 1;
      mcnt[which]++;
      if (outcome == 2) begin
        mstate[which] = 2;
        mwinner[which] = mplayer[which];
      end else if (outcome == 3) begin
        mstate[which] = 3;
      end else begin
        mplayer[which] ^= 1;
      end
    end
    press(which, a, b);
    expect_val(which, KIND_CELL, a, mboard[which][a]);
    if (b >= 0) expect_val(which, KIND_CELL, b, mboard[which][b]);
    expect_val(which, KIND_PLAYER, 0, mplayer[which]);
    expect_val(which, KIND_STATE, 0, mstate[which]);
    expect_val(which, KIND_CNT, 0, mcnt[which]);
    if (mstate[which] == 2) expect_val(which, KIND_WINNER, 0, mwinner[which]);
    drain();
  endtask

  task automatic do_restart();
    @(negedge CLK);
    restart = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
    model_clear();
    for (int i = 0; i < 9; i++) expect_val(0, KIND_CELL, i, 0);
    expect_val(0, KIND_PLAYER, 0, 0);
    expect_val(0, KIND_STATE, 0, 0);
    expect_val(0, KIND_CNT, 0, 0);
    expect_val(1, KIND_STATE, 0, 0);
    expect_val(1, KIND_CNT, 0, 0);
    drain();
  endtask

  initial begin
    int found;
    RST = 1'b0; restart = 1'b0; vnotactive = 1'b1;
    btn3 = '1; btn5 = '1; rd_idx3 = '0; rd_idx5 = '0;
    model_clear();
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // reset state
    expect_val(0, KIND_STATE, 0, 0);
    expect_val(0, KIND_PLAYER, 0, 0);
    expect_val(0, KIND_WINNER, 0, 0);
    expect_val(0, KIND_CNT, 0, 0);
    expect_val(0, KIND_CELL, 0, 0);
    expect_val(0, KIND_CELL, 8, 0);
    expect_val(1, KIND_STATE, 0, 0);
    expect_val(1, KIND_CNT, 0, 0);
    drain();

    // 3x3 top-row win for player 0, then a press in WIN is ignored
    move(0, 0, -1, 0);
    move(0, 3, -1, 0);
    move(0, 1, -1, 0);
    move(0, 4, -1, 0);
    move(0, 2, -1, 2);
    check("n3_win_latency_le9", 32'(last_lat >= 1 && last_lat <= 9), 32'd1);
    move(0, 5, -1, 0);

    // full board with no line
    do_restart();
    for (int i = 0; i < 9; i++) move(0, draw_ord[i], -1, (i == 8) ? 3 : 0);

    // commit held off until vertical blanking
    do_restart();
    vnotactive = 1'b0;
    press(0, 4, -1);
    expect_val(0, KIND_CELL, 4, 0);
    expect_val(0, KIND_CNT, 0, 0);
    expect_val(0, KIND_STATE, 0, 0);
    drain();
    @(negedge CLK);
    rd_idx3 = 4'd4;
    vnotactive = 1'b1;
    #1;
    check("n3_cell4_before_vblank_edge", 32'(rd_cell3), 32'd0);
    @(negedge CLK);
    check("n3_cell4_after_vblank_edge", 32'(rd_cell3), 32'd1);
    mboard[0][4] = 1; mcnt[0] = 1; mplayer[0] = 1;
    repeat (30) @(negedge CLK);
    expect_val(0, KIND_PLAYER, 0, mplayer[0]);
    expect_val(0, KIND_CNT, 0, mcnt[0]);
    drain();

    // simultaneous presses: lowest index wins; re-press of occupied cell ignored
    move(0, 2, 7, 0);
    move(0, 4, -1, 0);

    // 5x5 K=4 anti-diagonal win
    do_restart();
    move(1, 4, -1, 0);
    move(1, 0, -1, 0);
    move(1, 8, -1, 0);
    move(1, 1, -1, 0);
    move(1, 12, -1, 0);
    move(1, 2, -1, 0);
    move(1, 16, -1, 2);

    // row run must not wrap from row 0 into row 1
    do_restart();
    move(1, 3, -1, 0);
    move(1, 10, -1, 0);
    move(1, 4, -1, 0);
    move(1, 11, -1, 0);
    move(1, 5, -1, 0);
    move(1, 12, -1, 0);
    move(1, 6, -1, 0);

    // asynchronous reset in the middle of a scan
    do_restart();
    rd_idx3 = 4'd0;
    found = 0;
    @(negedge CLK);
    btn3[0] = 1'b0;
    for (int cy = 0; cy < 20 && found == 0; cy++) begin
      @(negedge CLK);
      if (cy == 3) btn3[0] = 1'b1;
      if (state3 == 2'd1) found = 1;
    end
    btn3[0] = 1'b1;
    check("n3_reached_check", 32'(found), 32'd1);
    RST = 1'b0;
    #1;
    check("n3_rst_state", 32'(state3), 32'd0);
    check("n3_rst_player", 32'(player3), 32'd0);
    check("n3_rst_move_cnt", 32'(move_cnt3), 32'd0);
    check("n3_rst_cell0", 32'(rd_cell3), 32'd0);
    check("n3_rst_winner", 32'(winner3), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    model_clear();
    repeat (2) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
